axis_stream_scoreboard: RTL and testbench

- Synthesizable AXI-stream outbound checker, the parametrised successor of the file-driven outbound compare loop.
- Buffers an expected-beat stream in an internal FIFO and passively monitors the engine outbound port (ob_*).
- Compares every accepted beat field-by-field, derives expected tlast from CQE framing, and masks data compare on stats-frame EoT beats.
- Runs a progress watchdog and keeps saturating error and beat counters; used in emulation and in block benches.

---
 rtl/axis_stream_scoreboard.sv | 166 ++++++++++++++++
 tb/tb_axis_stream_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_scoreboard.sv
// Purpose: passive AXI-stream outbound checker; buffers expected beats and compares each accepted ob_* beat.
// Latency: a beat pops and compares in its own cycle; err_pulse/err_cnt/beat_cnt update one cycle later.
// Backpressure: never stalls ob_*; exp_tready = !full, registered from occupancy (no push-through on full pop).
// Ports: clk/rst; exp_* expected-beat input stream; ob_* monitored port (tvalid&tready = beat);
//        err_pulse {last,strb,user,data}, saturating err_cnt/beat_cnt, sticky underflow/wdog_expired, idle.
module axis_stream_scoreboard #(
  parameter int DWIDTH     = 64,
  parameter int SWIDTH     = DWIDTH / 8,
  parameter int UWIDTH     = 8,
  parameter int IDWIDTH    = 4,
  parameter int EXP_DEPTH  = 16,
  parameter int WDOG_LIMIT = 10000,
  parameter int CNT_WIDTH  = 16,
  parameter int CHECK_TID  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exp_tvalid,
  output logic                 exp_tready,
  input  logic [DWIDTH-1:0]    exp_tdata,
  input  logic [UWIDTH-1:0]    exp_tuser,
  input  logic [SWIDTH-1:0]    exp_tstrb,
  input  logic [IDWIDTH-1:0]   exp_tid,
  input  logic                 ob_tvalid,
  input  logic                 ob_tready,
  input  logic [DWIDTH-1:0]    ob_tdata,
  input  logic [UWIDTH-1:0]    ob_tuser,
  input  logic [SWIDTH-1:0]    ob_tstrb,
  input  logic [IDWIDTH-1:0]   ob_tid,
  input  logic                 ob_tlast,
  output logic [3:0]           err_pulse,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 underflow,
  output logic                 wdog_expired,
  output logic                 idle
);

  localparam int AW  = $clog2(EXP_DEPTH);
  localparam int WDW = $clog2(WDOG_LIMIT + 1);

  typedef struct packed {
    logic [IDWIDTH-1:0] id;
    logic [SWIDTH-1:0]  strb;
    logic [UWIDTH-1:0]  user;
    logic [DWIDTH-1:0]  data;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_CQE, S_STATS, S_DATA} frame_state_t;

  beat_t          mem [EXP_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count_q, count_d;
  logic           rdy_q;
  logic           empty, push, ob_beat, pop;
  beat_t          head;

  frame_state_t   state_q, state_d, eff_state;
  logic           sot, eot, exp_last;
  logic [3:0]     flags;

  logic           pend_q;
  logic [WDW-1:0] wd_cnt;

  assign empty      = (count_q == '0);
  assign push       = exp_tvalid & rdy_q;
  assign ob_beat    = ob_tvalid & ob_tready;
  assign pop        = ob_beat & ~empty;
  assign head       = mem[rd_ptr];
  assign exp_tready = rdy_q;
  assign idle       = empty & ~pend_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: exp_tid, strb: exp_tstrb, user: exp_tuser, data: exp_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      rdy_q   <= (count_d != (AW + 1)'(EXP_DEPTH));
    end
  end

  // Frame tracking. An SoT picks the frame type for its own beat, so the
  // tlast/stats-mask decisions use eff_state rather than the registered state.
  assign sot = (head.user == UWIDTH'(1));
  assign eot = (head.user == UWIDTH'(2));

  always_comb begin
    eff_state = state_q;
    if (sot) begin
      if (head.data[7:0] == 8'h09)      eff_state = S_CQE;
      else if (head.data[7:0] == 8'h08) eff_state = S_STATS;
      else                              eff_state = S_DATA;
    end
    state_d = state_q;
    if (pop) begin
      state_d = eff_state;
      if (eot) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign exp_last = eot & (eff_state == S_CQE);

  always_comb begin
    flags    = '0;
    flags[0] = (ob_tdata != head.data) & ~(eot & (eff_state == S_STATS));
    flags[1] = (ob_tuser != head.user) | ((CHECK_TID != 0) & (ob_tid != head.id));
    flags[2] = (ob_tstrb != head.strb);
    flags[3] = (ob_tlast != exp_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= '0;
      err_cnt   <= '0;
      beat_cnt  <= '0;
      underflow <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      pend_q    <= ob_beat;
      err_pulse <= pop ? flags : 4'b0000;
      if (ob_beat & empty) underflow <= 1'b1;
      if (((pop & (|flags)) | (ob_beat & empty)) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
      if (pop && (beat_cnt != '1))
        beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Watchdog: counts stalled cycles while expected beats are waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt       <= '0;
      wdog_expired <= 1'b0;
    end else if (empty || ob_beat) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WDW'(WDOG_LIMIT)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt >= WDW'(WDOG_LIMIT - 1)) wdog_expired <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_stream_scoreboard.sv
// Purpose: directed self-checking bench for axis_stream_scoreboard (two instances sharing stimulus).
// Latency: results sampled on the negedge following each beat's posedge.
// Backpressure: stimulus honours exp_tready where the scenario expects acceptance.
module tb_axis_stream_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exp_tvalid = 1'b0;
  logic [63:0] exp_tdata = '0;
  logic [7:0]  exp_tuser = '0;
  logic [7:0]  exp_tstrb = '0;
  logic [3:0]  exp_tid = '0;
  logic        ob_tvalid = 1'b0;
  logic        ob_tready = 1'b0;
  logic [63:0] ob_tdata = '0;
  logic [7:0]  ob_tuser = '0;
  logic [7:0]  ob_tstrb = '0;
  logic [3:0]  ob_tid = '0;
  logic        ob_tlast = 1'b0;

  logic        exp_tready, exp_tready_s;
  logic [3:0]  err_pulse, err_pulse_s;
  logic [15:0] err_cnt, beat_cnt;
  logic [1:0]  err_cnt_s, beat_cnt_s;
  logic        underflow, underflow_s, wdog_expired, wdog_expired_s, idle, idle_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_stream_scoreboard #(
    .DWIDTH(64), .UWIDTH(8), .IDWIDTH(4), .EXP_DEPTH(4),
    .WDOG_LIMIT(8), .CNT_WIDTH(16), .CHECK_TID(1)
  ) dut (
    .clk(clk), .rst(rst),
    .exp_tvalid(exp_tvalid), .exp_tready(exp_tready), .exp_tdata(exp_tdata),
    .exp_tuser(exp_tuser), .exp_tstrb(exp_tstrb), .exp_tid(exp_tid),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata),
    .ob_tuser(ob_tuser), .ob_tstrb(ob_tstrb), .ob_tid(ob_tid), .ob_tlast(ob_tlast),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .beat_cnt(beat_cnt),
    .underflow(underflow), .wdog_expired(wdog_expired), .idle(idle)
  );

  axis_stream_scoreboard #(
    .DWIDTH(64), .UWIDTH(8), .IDWIDTH(4), .EXP_DEPTH(4),
    .WDOG_LIMIT(8), .CNT_WIDTH(2), .CHECK_TID(0)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .exp_tvalid(exp_tvalid), .exp_tready(exp_tready_s), .exp_tdata(exp_tdata),
    .exp_tuser(exp_tuser), .exp_tstrb(exp_tstrb), .exp_tid(exp_tid),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata),
    .ob_tuser(ob_tuser), .ob_tstrb(ob_tstrb), .ob_tid(ob_tid), .ob_tlast(ob_tlast),
    .err_pulse(err_pulse_s), .err_cnt(err_cnt_s), .beat_cnt(beat_cnt_s),
    .underflow(underflow_s), .wdog_expired(wdog_expired_s), .idle(idle_s)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus: optional push and/or observed beat, then lands on the next negedge.
  task automatic drive(input bit p, input logic [63:0] pd, input logic [7:0] pu,
                       input logic [7:0] ps, input logic [3:0] pi,
                       input bit o, input logic [63:0] od, input logic [7:0] ou,
                       input logic [7:0] os, input logic [3:0] oi, input bit ol);
    exp_tvalid = p;  exp_tdata = pd; exp_tuser = pu; exp_tstrb = ps; exp_tid = pi;
    ob_tvalid  = o;  ob_tready = o;  ob_tdata = od;  ob_tuser = ou;  ob_tstrb = os;
    ob_tid     = oi; ob_tlast  = ol;
    @(negedge clk);
    exp_tvalid = 1'b0;
    ob_tvalid  = 1'b0;
    ob_tready  = 1'b0;
    ob_tlast   = 1'b0;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] u, input logic [7:0] s, input logic [3:0] i);
    drive(1'b1, d, u, s, i, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic obs(input logic [63:0] d, input logic [7:0] u, input logic [7:0] s,
                     input logic [3:0] i, input bit l);
    drive(1'b0, '0, '0, '0, '0, 1'b1, d, u, s, i, l);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_val("rst_err_cnt",  err_cnt, 0);
    chk_val("rst_beat_cnt", beat_cnt, 0);
    chk_val("rst_pulse",    err_pulse, 0);
    chk_val("rst_underflow", underflow, 0);
    chk_val("rst_wdog",     wdog_expired, 0);
    chk_val("rst_idle",     idle, 1);
    chk_val("rst_tready",   exp_tready, 1);

    // Clean CQE frame
    push(64'h0123_4567_89AB_CD09, 8'h01, 8'hFF, 4'h0);
    push(64'h0000_0000_0000_1111, 8'h03, 8'hFF, 4'h0);
    push(64'h0000_0000_0000_2222, 8'h02, 8'h0F, 4'h0);
    obs(64'h0123_4567_89AB_CD09, 8'h01, 8'hFF, 4'h0, 1'b0);
    obs(64'h0000_0000_0000_1111, 8'h03, 8'hFF, 4'h0, 1'b0);
    obs(64'h0000_0000_0000_2222, 8'h02, 8'h0F, 4'h0, 1'b1);
    chk_val("cqe_pulse",    err_pulse, 0);
    chk_val("cqe_err_cnt",  err_cnt, 0);
    chk_val("cqe_beat_cnt", beat_cnt, 3);
    chk_val("cqe_idle_pend", idle, 0);
    @(negedge clk);
    chk_val("cqe_idle",     idle, 1);

    // CQE frame with tlast missing on EoT
    do_reset();
    push(64'h0000_0000_0000_0009, 8'h01, 8'hFF, 4'h0);
    push(64'h0000_0000_0000_1111, 8'h03, 8'hFF, 4'h0);
    push(64'h0000_0000_0000_2222, 8'h02, 8'hFF, 4'h0);
    obs(64'h0000_0000_0000_0009, 8'h01, 8'hFF, 4'h0, 1'b0);
    obs(64'h0000_0000_0000_1111, 8'h03, 8'hFF, 4'h0, 1'b0);
    chk_val("cqe_mid_pulse", err_pulse, 0);
    obs(64'h0000_0000_0000_2222, 8'h02, 8'hFF, 4'h0, 1'b0);
    chk_val("nolast_pulse",  err_pulse, 4'b1000);
    chk_val("nolast_errcnt", err_cnt, 1);
    @(negedge clk);
    chk_val("nolast_pulse_once", err_pulse, 0);

    // Stats frame: EoT data masked, strobe still checked; data frame EoT not masked
    do_reset();
    push(64'h0000_0000_0000_0008, 8'h01, 8'hFF, 4'h0);
    push(64'h0000_0000_0000_DEAD, 8'h02, 8'hFF, 4'h0);
    obs(64'h0000_0000_0000_0008, 8'h01, 8'hFF, 4'h0, 1'b0);
    obs(64'h0000_0000_0000_BEEF, 8'h02, 8'hFF, 4'h0, 1'b0);
    chk_val("stats_mask_pulse", err_pulse, 0);
    chk_val("stats_mask_cnt",   err_cnt, 0);
    push(64'h0000_0000_0000_0008, 8'h01, 8'hFF, 4'h0);
    push(64'h0000_0000_0000_DEAD, 8'h02, 8'hFF, 4'h0);
    obs(64'h0000_0000_0000_0008, 8'h01, 8'hFF, 4'h0, 1'b0);
    obs(64'h0000_0000_0000_DEAD, 8'h02, 8'h0F, 4'h0, 1'b0);
    chk_val("stats_strb_pulse", err_pulse, 4'b0100);
    chk_val("stats_strb_cnt",   err_cnt, 1);
    push(64'h0000_0000_0000_0005, 8'h01, 8'hFF, 4'h0);
    push(64'h0000_0000_0000_00AA, 8'h02, 8'hFF, 4'h0);
    obs(64'h0000_0000_0000_0005, 8'h01, 8'hFF, 4'h0, 1'b0);
    obs(64'h0000_0000_0000_00AB, 8'h02, 8'hFF, 4'h0, 1'b0);
    chk_val("data_eot_pulse", err_pulse, 4'b0001);
    chk_val("data_eot_cnt",   err_cnt, 2);
    // tid mismatch: only the CHECK_TID instance flags it, in the user bit
    push(64'h0000_0000_0000_0005, 8'h01, 8'hFF, 4'h3);
    obs(64'h0000_0000_0000_0005, 8'h01, 8'hFF, 4'h5, 1'b0);
    chk_val("tid_pulse",        err_pulse, 4'b0010);
    chk_val("tid_pulse_notid",  err_pulse_s, 4'b0000);
    chk_val("tid_cnt",          err_cnt, 3);
    chk_val("tid_cnt_notid",    err_cnt_s, 2);

    // Fill to depth; pop on full must not admit a same-cycle push
    do_reset();
    for (int k = 0; k < 4; k++) push(64'h10 + 64'(k), 8'h03, 8'hFF, 4'h0);
    chk_val("full_tready", exp_tready, 0);
    drive(1'b1, 64'h14, 8'h03, 8'hFF, 4'h0, 1'b1, 64'h10, 8'h03, 8'hFF, 4'h0, 1'b0);
    chk_val("popfull_tready", exp_tready, 1);
    chk_val("popfull_uflow",  underflow, 0);
    chk_val("popfull_pulse",  err_pulse, 0);
    push(64'h15, 8'h03, 8'hFF, 4'h0);
    chk_val("refill_tready", exp_tready, 0);
    obs(64'h11, 8'h03, 8'hFF, 4'h0, 1'b0);
    obs(64'h12, 8'h03, 8'hFF, 4'h0, 1'b0);
    obs(64'h13, 8'h03, 8'hFF, 4'h0, 1'b0);
    obs(64'h15, 8'h03, 8'hFF, 4'h0, 1'b0);
    chk_val("order_err_cnt",  err_cnt, 0);
    chk_val("order_beat_cnt", beat_cnt, 5);
    chk_val("order_uflow",    underflow, 0);

    // Underflow
    do_reset();
    obs(64'h1, 8'h03, 8'hFF, 4'h0, 1'b0);
    chk_val("uflow_flag",  underflow, 1);
    chk_val("uflow_cnt",   err_cnt, 1);
    chk_val("uflow_pulse", err_pulse, 0);
    chk_val("uflow_beats", beat_cnt, 0);

    // Watchdog at limit 8
    do_reset();
    push(64'h1, 8'h03, 8'hFF, 4'h0);
    repeat (7) @(negedge clk);
    chk_val("wdog_before", wdog_expired, 0);
    @(negedge clk);
    chk_val("wdog_after",  wdog_expired, 1);
    chk_val("wdog_idle",   idle, 0);

    // Saturation
    do_reset();
    for (int k = 0; k < 5; k++) obs(64'h1, 8'h03, 8'hFF, 4'h0, 1'b0);
    chk_val("sat_err_wide", err_cnt, 5);
    chk_val("sat_err_2b",   err_cnt_s, 3);
    for (int k = 0; k < 4; k++) push(64'h20 + 64'(k), 8'h03, 8'hFF, 4'h0);
    for (int k = 0; k < 4; k++) obs(64'h20 + 64'(k), 8'h03, 8'hFF, 4'h0, 1'b0);
    chk_val("sat_beat_wide", beat_cnt, 4);
    chk_val("sat_beat_2b",   beat_cnt_s, 3);
    chk_val("sat_err_hold",  err_cnt_s, 3);

    // Reset mid-frame (inside a CQE frame with a beat still queued)
    do_reset();
    push(64'h0000_0000_0000_0009, 8'h01, 8'hFF, 4'h0);
    obs(64'h0000_0000_0000_0009, 8'h01, 8'hFF, 4'h0, 1'b0);
    obs(64'h1, 8'h03, 8'hFF, 4'h0, 1'b0);
    push(64'h0000_0000_0000_3333, 8'h03, 8'hFF, 4'h0);
    chk_val("mid_pre_uflow", underflow, 1);
    do_reset();
    chk_val("mid_rst_err",    err_cnt, 0);
    chk_val("mid_rst_beat",   beat_cnt, 0);
    chk_val("mid_rst_pulse",  err_pulse, 0);
    chk_val("mid_rst_uflow",  underflow, 0);
    chk_val("mid_rst_idle",   idle, 1);
    chk_val("mid_rst_tready", exp_tready, 1);
    // FSM back in IDLE: a bare EoT expects tlast 0; FIFO flushed: head is this beat
    push(64'h0000_0000_0000_00AA, 8'h02, 8'hFF, 4'h0);
    obs(64'h0000_0000_0000_00AA, 8'h02, 8'hFF, 4'h0, 1'b0);
    chk_val("mid_post_pulse", err_pulse, 0);
    chk_val("mid_post_beat",  beat_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
